vram_touch_painter: RTL

- Owns the VRAM write port for the etch-a-sketch and replaces the ad-hoc clearing logic in the top level.
- Clears VRAM to a background colour after reset or on request.
- Afterwards, round-robins over N touch channels and paints a clipped square brush, in a per-channel colour, around each new touch point.
- Sits between the ft6206 touch controller outputs and the block_ram write port; the ili9341 controller keeps the read port.

---
 rtl/painter_pkg.sv | 21 ++
 rtl/vram_touch_painter_brush_scanner.sv | 85 ++++++++
 rtl/vram_touch_painter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/painter_pkg.sv
// Shared definitions for the VRAM touch painter.
//   painter_state_t : top-level sequencing state (clear / idle / paint)
//   ILI9341_color_t : 16-bit RGB565 pixel colour used by the display path
//   pix_addr()      : linear VRAM address of pixel (x, y) in a row-major frame
package painter_pkg;

  typedef logic [15:0] ILI9341_color_t;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_PAINT
  } painter_state_t;

  function automatic int unsigned pix_addr(input int unsigned x,
                                           input int unsigned y,
                                           input int unsigned width);
    return y * width + x;
  endfunction

endpackage

// File: rtl/vram_touch_painter_brush_scanner.sv
// Walks a square brush of radius r around a centre point, one offset per
// cycle, row by row (dy outer, dx inner), and flags pixels that fall outside
// the display so the caller can suppress the write.
// Ports:
//   clk, rstb          clock, asynchronous active-low reset
//   start              load centre/radius and begin the scan next cycle
//   abort              stop the scan immediately
//   cx, cy, radius     brush centre and radius, sampled on start
//   px, py             pixel coordinate for the current offset
//   in_bounds          current pixel lies on the display (and scan is active)
//   done               current offset is the last one of the scan
module brush_scanner #(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int XW             = 8,
  parameter int YW             = 9,
  parameter int RW             = 3
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] cx,
  input  logic [YW-1:0] cy,
  input  logic [RW-1:0] radius,
  output logic [XW-1:0] px,
  output logic [YW-1:0] py,
  output logic          in_bounds,
  output logic          done
);

  localparam logic signed [RW:0] ONE = (RW+1)'(1);

  logic                 active_p0;
  logic signed [RW:0]   r_p0;
  logic signed [RW:0]   dx_p0;
  logic signed [RW:0]   dy_p0;
  logic signed [XW:0]   cx_p0;
  logic signed [YW:0]   cy_p0;
  logic signed [XW:0]   sx;
  logic signed [YW:0]   sy;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      active_p0 <= 1'b0;
    end else if (abort) begin
      active_p0 <= 1'b0;
    end else if (start) begin
      active_p0 <= 1'b1;
    end else if (done) begin
      active_p0 <= 1'b0;
    end
  end

  // Stage p0: offset counters, start at (-r, -r) and end at (r, r)
  always_ff @(posedge clk) begin
    if (start) begin
      r_p0  <= $signed({1'b0, radius});
      dx_p0 <= -$signed({1'b0, radius});
      dy_p0 <= -$signed({1'b0, radius});
      cx_p0 <= $signed({1'b0, cx});
      cy_p0 <= $signed({1'b0, cy});
    end else if (active_p0) begin
      if (dx_p0 == r_p0) begin
        dx_p0 <= -r_p0;
        dy_p0 <= dy_p0 + ONE;
      end else begin
        dx_p0 <= dx_p0 + ONE;
      end
    end
  end

  // One extra bit lets negative coordinates show up in the sign bit
  // instead of wrapping to the far edge.
  always_comb begin
    sx        = cx_p0 + (XW+1)'(dx_p0);
    sy        = cy_p0 + (YW+1)'(dy_p0);
    px        = sx[XW-1:0];
    py        = sy[YW-1:0];
    in_bounds = active_p0 && !sx[XW] && (int'(sx) < DISPLAY_WIDTH)
                          && !sy[YW] && (int'(sy) < DISPLAY_HEIGHT);
    done      = active_p0 && (dx_p0 == r_p0) && (dy_p0 == r_p0);
  end

endmodule

// File: rtl/vram_touch_painter.sv
// Owns the VRAM write port: clears the frame to CLEAR_COLOR after reset or on
// clear_req, then round-robins the touch channels and paints a clipped square
// brush around every new touch point.
// Ports:
//   clk, rstb                 clock, asynchronous active-low reset
//   clear_req                 one-cycle pulse, restart the full clear (aborts a paint)
//   erase_mode                paint CLEAR_COLOR instead of the channel colour
//   brush_radius              requested radius, clamped to BRUSH_MAX at capture
//   touch_valid/x/y/color     packed per-channel touch data, channel 0 in LSBs
//   vram_wr_ena/addr/data     registered VRAM write port
//   busy                      clearing or painting
//   cleared                   a full clear has completed since reset
module vram_touch_painter
  import painter_pkg::*;
#(
  parameter int              DISPLAY_WIDTH  = 240,
  parameter int              DISPLAY_HEIGHT = 320,
  parameter int              VRAM_W         = 16,
  parameter int              N_TOUCH        = 2,
  parameter int              BRUSH_MAX      = 7,
  parameter logic [VRAM_W-1:0] CLEAR_COLOR  = '0,
  localparam int             VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  localparam int             AW             = $clog2(VRAM_L),
  localparam int             XW             = $clog2(DISPLAY_WIDTH),
  localparam int             YW             = $clog2(DISPLAY_HEIGHT),
  localparam int             RW             = $clog2(BRUSH_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        clear_req,
  input  logic                        erase_mode,
  input  logic [RW-1:0]               brush_radius,
  input  logic [N_TOUCH-1:0]          touch_valid,
  input  logic [N_TOUCH*XW-1:0]       touch_x,
  input  logic [N_TOUCH*YW-1:0]       touch_y,
  input  logic [N_TOUCH*VRAM_W-1:0]   touch_color,
  output logic                        vram_wr_ena,
  output logic [AW-1:0]               vram_wr_addr,
  output logic [VRAM_W-1:0]           vram_wr_data,
  output logic                        busy,
  output logic                        cleared
);

  localparam int              PW       = (N_TOUCH > 1) ? $clog2(N_TOUCH) : 1;
  localparam logic [AW:0]     CLR_END  = (AW+1)'(VRAM_L);
  localparam logic [PW-1:0]   PTR_LAST = PW'(N_TOUCH - 1);

  function automatic logic [RW-1:0] clamp_radius(input logic [RW-1:0] r);
    return (32'(r) > 32'(BRUSH_MAX)) ? RW'(BRUSH_MAX) : r;
  endfunction

  painter_state_t       state_p0;
  logic [AW:0]          clr_cnt_p0;
  logic [PW-1:0]        ptr_p0;
  logic [PW-1:0]        ptr_nxt;
  logic [N_TOUCH-1:0]   last_vld_p0;
  logic [XW-1:0]        last_x_p0 [N_TOUCH];
  logic [YW-1:0]        last_y_p0 [N_TOUCH];
  logic [VRAM_W-1:0]    color_p0;

  logic                 sel_valid;
  logic [XW-1:0]        sel_x;
  logic [YW-1:0]        sel_y;
  logic [VRAM_W-1:0]    sel_color;
  logic [RW-1:0]        r_sel;
  logic                 capture;

  logic [XW-1:0]        px;
  logic [YW-1:0]        py;
  logic                 in_bounds;
  logic                 done;

  // Channel under examination; a touch is new only if it moved or was lifted.
  always_comb begin
    sel_valid = touch_valid[ptr_p0];
    sel_x     = touch_x[ptr_p0*XW +: XW];
    sel_y     = touch_y[ptr_p0*YW +: YW];
    sel_color = touch_color[ptr_p0*VRAM_W +: VRAM_W];
    r_sel     = clamp_radius(brush_radius);
    ptr_nxt   = (ptr_p0 == PTR_LAST) ? '0 : ptr_p0 + 1'b1;
    capture   = (state_p0 == S_IDLE) && !clear_req && sel_valid &&
                (!last_vld_p0[ptr_p0] || (sel_x != last_x_p0[ptr_p0]) ||
                 (sel_y != last_y_p0[ptr_p0]));
  end

  brush_scanner #(
    .DISPLAY_WIDTH  (DISPLAY_WIDTH),
    .DISPLAY_HEIGHT (DISPLAY_HEIGHT),
    .XW             (XW),
    .YW             (YW),
    .RW             (RW)
  ) u_scan (
    .clk       (clk),
    .rstb      (rstb),
    .start     (capture),
    .abort     (clear_req),
    .cx        (sel_x),
    .cy        (sel_y),
    .radius    (r_sel),
    .px        (px),
    .py        (py),
    .in_bounds (in_bounds),
    .done      (done)
  );

  // Stage p0: captured stroke data (last point for dedupe, paint colour)
  always_ff @(posedge clk) begin
    if (capture) begin
      last_x_p0[ptr_p0] <= sel_x;
      last_y_p0[ptr_p0] <= sel_y;
      color_p0          <= erase_mode ? CLEAR_COLOR : sel_color;
    end
  end

  // Stage p1: sequencing and registered write port
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_p0     <= S_CLEAR;
      clr_cnt_p0   <= '0;
      ptr_p0       <= '0;
      last_vld_p0  <= '0;
      vram_wr_ena  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      busy         <= 1'b1;
      cleared      <= 1'b0;
    end else if (clear_req) begin
      state_p0    <= S_CLEAR;
      clr_cnt_p0  <= '0;
      vram_wr_ena <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state_p0)
        S_CLEAR: begin
          // Counter runs one past the last address so 'cleared' rises the
          // cycle after the final clear write.
          if (clr_cnt_p0 == CLR_END) begin
            state_p0    <= S_IDLE;
            vram_wr_ena <= 1'b0;
            busy        <= 1'b0;
            cleared     <= 1'b1;
            last_vld_p0 <= '0;
          end else begin
            vram_wr_ena  <= 1'b1;
            vram_wr_addr <= clr_cnt_p0[AW-1:0];
            vram_wr_data <= CLEAR_COLOR;
            clr_cnt_p0   <= clr_cnt_p0 + 1'b1;
          end
        end
        S_IDLE: begin
          vram_wr_ena <= 1'b0;
          if (capture) begin
            state_p0            <= S_PAINT;
            busy                <= 1'b1;
            last_vld_p0[ptr_p0] <= 1'b1;
          end else begin
            if (!sel_valid) begin
              last_vld_p0[ptr_p0] <= 1'b0;
            end
            ptr_p0 <= ptr_nxt;
          end
        end
        S_PAINT: begin
          vram_wr_ena  <= in_bounds;
          vram_wr_addr <= AW'(pix_addr(32'(px), 32'(py), DISPLAY_WIDTH));
          vram_wr_data <= color_p0;
          if (done) begin
            state_p0 <= S_IDLE;
            busy     <= 1'b0;
            ptr_p0   <= ptr_nxt;
          end
        end
        default: begin
          state_p0 <= S_IDLE;
        end
      endcase
    end
  end

endmodule
